// File: rtl/car_speed_pkg.sv
// Shared types and helpers for the car speed governor.
// The CAR_SPEED_CRUISE_EN build option is consumed by car_speed_governor.sv.
package car_speed_pkg;

   typedef enum logic [1:0] {
      ST_OFF    = 2'b00,
      ST_DRIVE  = 2'b01,
      ST_CRUISE = 2'b10
   } state_t;

   localparam logic [1:0] ENC_OFF    = 2'b00;
   localparam logic [1:0] ENC_DRIVE  = 2'b01;
   localparam logic [1:0] ENC_CRUISE = 2'b10;

   // Counter width for a modulus of n, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/car_speed_ramp_timer.sv
// Acceleration ramp timer: emits a one-cycle step every STEP_DELAY enabled cycles.
// Clear has priority over enable; the count restarts from zero after any clear.
module car_speed_ramp_timer
   import car_speed_pkg::*;
#(
   parameter int STEP_DELAY = 1
) (
   input  logic clock,
   input  logic reset_n,
   input  logic enable,
   input  logic clear,
   output logic step
);

   localparam int CNT_W = clog2_min1(STEP_DELAY);
   localparam logic [CNT_W-1:0] TC = CNT_W'(STEP_DELAY - 1);

   logic [CNT_W-1:0] cnt_q;

   assign step = enable && !clear && (cnt_q == TC);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable) begin
         if (cnt_q == TC) cnt_q <= '0;
         else             cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/car_speed_governor.sv
// Speed governor top: OFF/DRIVE/CRUISE FSM, saturating speed register and flag decode.
// Define CAR_SPEED_CRUISE_EN to build the cruise_set port and the CRUISE hold state.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   ST_OFF    | ignition off, speed forced to 0
//   ST_DRIVE  | pedals active: brake steps down, accelerate ramps up
//   ST_CRUISE | speed held; only brake (or keys off) exits
module car_speed_governor
   import car_speed_pkg::*;
#(
   parameter int SPEED_W    = 2,
   parameter int MAX_SPEED  = 3,
   parameter int STEP_DELAY = 1
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               keys,
   input  logic               brake,
   input  logic               accelerate,
`ifdef CAR_SPEED_CRUISE_EN
   input  logic               cruise_set,
`endif
   output logic [SPEED_W-1:0] speed,
   output logic               at_max,
   output logic               at_stop,
   output logic               cruise_active
);

   localparam logic [SPEED_W-1:0] MAX_S = SPEED_W'(MAX_SPEED);

   state_t             state_q, state_d;
   logic [SPEED_W-1:0] speed_q, speed_d;
   logic [SPEED_W-1:0] speed_inc, speed_dec;
   logic               ramp_en, ramp_clr, ramp_step;

   assign speed_inc = (speed_q == MAX_S) ? speed_q : speed_q + 1'b1;
   assign speed_dec = (speed_q == '0)    ? speed_q : speed_q - 1'b1;

   assign ramp_en  = keys && (state_q == ST_DRIVE) && !brake && accelerate;
   assign ramp_clr = !ramp_en;

   car_speed_ramp_timer #(
      .STEP_DELAY (STEP_DELAY)
   ) u_ramp (
      .clock   (clock),
      .reset_n (reset_n),
      .enable  (ramp_en),
      .clear   (ramp_clr),
      .step    (ramp_step)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_OFF;
         speed_q <= '0;
      end else begin
         state_q <= state_d;
         speed_q <= speed_d;
      end
   end

   always_comb begin
      state_d = state_q;
      speed_d = speed_q;
      if (!keys) begin
         state_d = ST_OFF;
         speed_d = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
               if (brake) begin
                  speed_d = speed_dec;
               end else if (accelerate) begin
                  if (ramp_step) speed_d = speed_inc;
`ifdef CAR_SPEED_CRUISE_EN
               end else if (cruise_set && (speed_q != '0)) begin
                  state_d = ST_CRUISE;
`endif
               end
            end
`ifdef CAR_SPEED_CRUISE_EN
            ST_CRUISE: begin
               if (brake) begin
                  speed_d = speed_dec;
                  state_d = ST_DRIVE;
               end
            end
`endif
            default: begin
               state_d = ST_OFF;
               speed_d = '0;
            end
         endcase
      end
   end

   assign speed   = speed_q;
   assign at_max  = (speed_q == MAX_S);
   assign at_stop = (speed_q == '0);
`ifdef CAR_SPEED_CRUISE_EN
   assign cruise_active = (state_q == ST_CRUISE);
`else
   assign cruise_active = 1'b0;
`endif

endmodule
